// File: rtl/btn_evt_pkg.sv
// Shared types for the button event controller: event kinds, per-button FSM
// states and the event record stored in the output FIFO.
package btn_evt_pkg;

    // Widest button index the event record can carry (up to 16 buttons).
    localparam int BTN_IDX_W = 4;

    typedef enum logic [1:0] {
        EVT_SHORT  = 2'b00,
        EVT_LONG   = 2'b01,
        EVT_REPEAT = 2'b10
    } evt_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HELD = 2'b01,
        ST_LONG = 2'b10
    } btn_state_t;

    typedef struct packed {
        logic [BTN_IDX_W-1:0] btn;
        evt_kind_t            kind;
    } evt_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_hold_fsm.sv
// Per-button hold classifier: turns press/release strobes into SHORT / LONG
// (and, with BTN_EVT_AUTOREPEAT_EN defined, REPEAT) events. The event output
// is combinational in the cycle the condition is detected.
module btn_hold_fsm
    import btn_evt_pkg::*;
#(
    parameter int LONG_CLKS   = 12500000,
    parameter int REPEAT_CLKS = 2500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       press_stb,
    input  logic       release_stb,
    output logic       evt_valid,
    output logic [1:0] evt_kind
);

    localparam int CNT_MAX = max_int(LONG_CLKS, REPEAT_CLKS);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CLKS - 1);
`ifdef BTN_EVT_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CLKS - 1);
`endif

    btn_state_t       state_reg, state_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             press_only, release_only;

    // A press and release in the same cycle cancel each other out.
    assign press_only   = press_stb & ~release_stb;
    assign release_only = release_stb & ~press_stb;

    // State and hold counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Next state, counter update and event detection; release beats a threshold hit.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        evt_valid     = 1'b0;
        evt_kind      = EVT_SHORT;
        case (state_reg)
            ST_IDLE: begin
                if (press_only) begin
                    state_next    = ST_HELD;
                    hold_cnt_next = '0;
                end
            end
            ST_HELD: begin
                if (release_only) begin
                    evt_valid     = 1'b1;
                    evt_kind      = EVT_SHORT;
                    state_next    = ST_IDLE;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == LONG_LAST) begin
                    evt_valid     = 1'b1;
                    evt_kind      = EVT_LONG;
                    state_next    = ST_LONG;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            ST_LONG: begin
                if (release_only) begin
                    state_next    = ST_IDLE;
                    hold_cnt_next = '0;
                end
`ifdef BTN_EVT_AUTOREPEAT_EN
                else if (hold_cnt_reg == REPEAT_LAST) begin
                    evt_valid     = 1'b1;
                    evt_kind      = EVT_REPEAT;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_next    = ST_IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Button event scheduler: per-button hold FSMs feed one pending slot each, a
// fixed-priority arbiter (lowest index wins) moves one slot per cycle into a
// first-word-fall-through FIFO read by the CPU. Events that find their slot
// occupied are dropped and flagged in the sticky overflow bit.
// Optional feature: define BTN_EVT_AUTOREPEAT_EN for REPEAT events while held.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int  NUM_BTNS    = 4,
    parameter int  LONG_CLKS   = 12500000,
    parameter int  REPEAT_CLKS = 2500000,
    parameter int  FIFO_DEPTH  = 4,
    localparam int BTN_W       = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_BTNS-1:0] i_press_stb,
    input  logic [NUM_BTNS-1:0] i_release_stb,
    output logic                o_evt_valid,
    input  logic                i_evt_ready,
    output logic [BTN_W-1:0]    o_evt_btn,
    output logic [1:0]          o_evt_kind,
    output logic                o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [NUM_BTNS-1:0] fsm_evt_valid;
    logic [1:0]          fsm_evt_kind [NUM_BTNS];

    logic [NUM_BTNS-1:0] pend_valid_reg;
    logic [1:0]          pend_kind_reg [NUM_BTNS];

    logic                grant_any;
    logic [BTN_W-1:0]    grant_idx;
    logic [1:0]          grant_kind;
    logic [NUM_BTNS-1:0] grant_onehot;
    logic [NUM_BTNS-1:0] grant_vec;

    evt_t                mem_reg [FIFO_DEPTH];
    evt_t                push_evt;
    evt_t                head_evt;
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]      count_reg;
    logic                push, pop, fifo_full;
    logic                overflow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_hold_fsm #(
                .LONG_CLKS   (LONG_CLKS),
                .REPEAT_CLKS (REPEAT_CLKS)
            ) u_hold_fsm (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .press_stb   (i_press_stb[gi]),
                .release_stb (i_release_stb[gi]),
                .evt_valid   (fsm_evt_valid[gi]),
                .evt_kind    (fsm_evt_kind[gi])
            );
        end
    endgenerate

    // Pending slots: an empty slot captures a new event; a granted slot clears.
    // A slot drained this cycle still counts as occupied for a same-cycle event.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (i_rst) begin
                pend_valid_reg[i] <= 1'b0;
                pend_kind_reg[i]  <= EVT_SHORT;
            end else if (!pend_valid_reg[i] && fsm_evt_valid[i]) begin
                pend_valid_reg[i] <= 1'b1;
                pend_kind_reg[i]  <= fsm_evt_kind[i];
            end else if (grant_vec[i]) begin
                pend_valid_reg[i] <= 1'b0;
            end
        end
    end

    // Fixed-priority arbiter: scan from the top so the lowest pending index wins.
    always_comb begin
        grant_any    = 1'b0;
        grant_idx    = '0;
        grant_kind   = EVT_SHORT;
        grant_onehot = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (pend_valid_reg[i]) begin
                grant_any       = 1'b1;
                grant_idx       = BTN_W'(i);
                grant_kind      = pend_kind_reg[i];
                grant_onehot    = '0;
                grant_onehot[i] = 1'b1;
            end
        end
    end

    assign fifo_full     = (count_reg == FIFO_FULL_CNT);
    assign o_evt_valid   = (count_reg != '0);
    assign pop           = o_evt_valid & i_evt_ready;
    assign push          = grant_any & (~fifo_full | pop);
    assign grant_vec     = push ? grant_onehot : '0;
    assign push_evt.btn  = BTN_IDX_W'(grant_idx);
    assign push_evt.kind = evt_kind_t'(grant_kind);

    // FIFO storage; contents need no reset because the outputs are gated by valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_evt;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)      count_reg <= count_reg + (PTR_W + 1)'(1);
            else if (pop && !push) count_reg <= count_reg - (PTR_W + 1)'(1);
        end
    end

    // Sticky overflow: any event that hits an occupied pending slot.
    always_ff @(posedge i_clk) begin
        if (i_rst)                                   overflow_reg <= 1'b0;
        else if (|(fsm_evt_valid & pend_valid_reg))  overflow_reg <= 1'b1;
    end

    assign head_evt   = mem_reg[rd_ptr_reg];
    assign o_evt_btn  = o_evt_valid ? BTN_W'(head_evt.btn) : '0;
    assign o_evt_kind = o_evt_valid ? head_evt.kind : EVT_SHORT;
    assign o_overflow = overflow_reg;

endmodule
